hazard_stall_controller: RTL and testbench
==========================================

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 4, register-address width.
REQ-002 SHALL have parameter LOAD_STALL_CYCLES, default 1, bubble cycles per load-use hazard; legal range 1..3.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 3, cycles allowed for in-flight instructions to retire after HALT; legal range 1..7.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 id_opcode  in  4  opcode of the instruction in ID.
REQ-007 id_rs1, id_rs2  in  REG_ADDR_W each  source registers of the ID instruction.
REQ-008 ex_mem_read  in  1  the EX-stage instruction is LW or LBU.
REQ-009 ex_rd  in  REG_ADDR_W  destination register of the EX instruction.
REQ-010 branch_taken  in  1  branch/jump resolved taken in ID.
REQ-011 exception  in  1  exception raised by any stage.
REQ-012 pc_write  out  1  PC update enable.
REQ-013 ifid_write  out  1  IF/ID register write enable.
REQ-014 idex_bubble  out  1  forces zero controls into ID/EX.
REQ-015 ifid_flush  out  1  zeroes IF/ID on the next edge.
REQ-016 halted  out  1  core is stopped.

Function
REQ-017 SHALL implement states RUN, STALL, DRAIN, HALTED; outputs are combinational from state and inputs.
REQ-018 Load-use hazard SHALL be: ex_mem_read=1, ex_rd!=0, and ex_rd equals id_rs1 or id_rs2.
REQ-019 In RUN with no event: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, halted=0.
REQ-020 In RUN on load-use: pc_write=0, ifid_write=0, idex_bubble=1 that cycle; go to STALL loading counter with LOAD_STALL_CYCLES-1, or stay RUN if that value is 0.
REQ-021 In STALL: same outputs as REQ-020; counter decrements each cycle; return to RUN when counter is 0.
REQ-022 In RUN on branch_taken without load-use: ifid_flush=1, pc_write=1; state unchanged.
REQ-023 Load-use and branch_taken in the same cycle: stall wins, ifid_flush=0; the branch re-evaluates after the stall.
REQ-024 In RUN with id_opcode=HALT (4'b1111) and no load-use: pc_write=0, ifid_write=0, idex_bubble=1; go to DRAIN with counter loaded DRAIN_CYCLES.
REQ-025 In DRAIN: pc_write=0, ifid_write=0, idex_bubble=1; counter decrements; go to HALTED when counter is 0.
REQ-026 In HALTED: pc_write=0, ifid_write=0, idex_bubble=1, halted=1; state sticky until reset; all inputs ignored.
REQ-027 exception=1 in RUN, STALL or DRAIN SHALL override everything that cycle: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=1; next state HALTED.
REQ-028 Priority SHALL be exception > load-use > HALT > branch_taken.

Reset
REQ-029 While rst_n=0 on a rising edge: state:=RUN, counter:=0, stall counter (if present):=0.
REQ-030 While rst_n=0, outputs SHALL be pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=1, halted=0; reset mid-STALL/DRAIN abandons the sequence.

Configuration
REQ-031 With macro HAZARD_STALL_COUNT_EN defined: add output stall_count (16 bits) counting cycles with pc_write=0 in RUN or STALL; saturates at 16'hFFFF; cleared by reset.
REQ-032 Without HAZARD_STALL_COUNT_EN: no stall_count port and no counter logic.

Structure
REQ-033 A shared package SHALL hold opcode constants (OP_LBU=4'b1010, OP_LW=4'b1100, OP_HALT=4'b1111) and the state encoding.
REQ-034 Sub-module hazard_detect (combinational REQ-018 comparator) SHALL be instantiated once.

Verification
REQ-035 ex_mem_read=1, ex_rd=3, id_rs2=3, LOAD_STALL_CYCLES=2 -> pc_write=0 for exactly 2 cycles, then RUN.
REQ-036 ex_rd=0 with ex_mem_read=1, id_rs1=0 -> no stall.
REQ-037 branch_taken=1 and load-use together -> ifid_flush=0, stall asserted; next cycle branch_taken=1 alone -> ifid_flush=1.
REQ-038 id_opcode=4'b1111, DRAIN_CYCLES=3 -> halted=1 on the 4th cycle after HALT is seen; stays 1 under any input until rst_n=0.
REQ-039 exception=1 during DRAIN -> ifid_flush=1 that cycle, halted=1 next cycle.
REQ-040 rst_n=0 during STALL -> next cycle RUN outputs; with HAZARD_STALL_COUNT_EN, stall_count=0.

Source files
------------

// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the hazard/stall controller: opcode constants,
// controller state encoding and the width of the stall/drain down-counter.
package hazard_stall_controller_pkg;

  localparam logic [3:0] OP_LBU  = 4'b1010;
  localparam logic [3:0] OP_LW   = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // Wide enough for the largest drain length (7) and stall reload (2).
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // True when the ID-stage opcode asks the core to stop.
  function automatic logic is_halt_op(input logic [3:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/hazard_stall_controller_hazard_detect.sv
// Load-use comparator: the EX-stage load writes a register that the
// ID-stage instruction reads, so ID must wait for the loaded data.
module hazard_detect #(
  parameter int REG_ADDR_W = 4
) (
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic                  load_use
);

  // Register 0 is hard-wired zero, so a load targeting it never hazards.
  assign load_use = ex_mem_read
                  && (ex_rd != '0)
                  && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: inserts load-use bubbles, flushes IF/ID
// on taken branches, drains and stops the core on HALT or an exception.
// Optional feature: define HAZARD_STALL_COUNT_EN to add a 16-bit saturating
// stall_count output counting pc_write=0 cycles in RUN or STALL.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int REG_ADDR_W        = 4,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int DRAIN_CYCLES      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken,
  input  logic                  exception,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic                  halted
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  // Extra STALL-state cycles after the RUN cycle that detects the hazard.
  localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             load_use;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .load_use    (load_use)
  );

  // Next-state, counter and pipeline-control decode from state and inputs.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves one unassigned, which would otherwise infer a latch.
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    halted      = 1'b0;
    state_next  = state;
    cnt_next    = cnt;

    unique case (state)
      ST_RUN: begin
        if (exception) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          ifid_flush  = 1'b1;
          state_next  = ST_HALTED;
          cnt_next    = '0;
        end else if (load_use) begin
          // Hold PC and IF/ID, bubble EX; a pending branch re-evaluates later.
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (STALL_LOAD != '0) begin
            state_next = ST_STALL;
            cnt_next   = STALL_LOAD;
          end
        end else if (is_halt_op(id_opcode)) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_next  = ST_DRAIN;
          cnt_next    = DRAIN_LOAD;
        end else if (branch_taken) begin
          ifid_flush  = 1'b1;
        end
      end

      ST_STALL, ST_DRAIN: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        if (exception) begin
          ifid_flush = 1'b1;
          state_next = ST_HALTED;
          cnt_next   = '0;
        end else if (cnt <= CNT_ONE) begin
          // Last counted cycle: STALL resumes RUN, DRAIN stops the core.
          state_next = (state == ST_STALL) ? ST_RUN : ST_HALTED;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt - CNT_ONE;
        end
      end

      ST_HALTED: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end

      default: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        state_next  = ST_RUN;
        cnt_next    = '0;
      end
    endcase

    // While reset is held the pipeline is frozen and IF/ID is cleared.
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
      halted      = 1'b0;
    end
  end

  // State and down-counter registers; reset abandons any stall or drain.
  always_ff @(posedge clk) begin
    // NOTE: state and counter use non-blocking assignments so all flops
    // update together on the edge; reset is synchronous, sampled here.
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  // Saturating count of front-end freeze cycles seen in RUN or STALL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (((state == ST_RUN) || (state == ST_STALL)) && !pc_write
                 && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller with
// LOAD_STALL_CYCLES=2 and DRAIN_CYCLES=3. Inputs change on the falling
// edge and outputs are checked 1 ns later, away from the rising edge.
module tb_hazard_stall_controller;

  localparam int RW = 4;

  // {pc_write, ifid_write, idex_bubble, ifid_flush, halted}
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_FLUSH = 5'b11010;
  localparam logic [4:0] O_STALL = 5'b00100;
  localparam logic [4:0] O_EXC   = 5'b00110;
  localparam logic [4:0] O_HALT  = 5'b00101;
  localparam logic [4:0] O_RST   = 5'b00110;

  logic          clk;
  logic          rst_n;
  logic [3:0]    id_opcode;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          ex_mem_read;
  logic [RW-1:0] ex_rd;
  logic          branch_taken;
  logic          exception;
  logic          pc_write;
  logic          ifid_write;
  logic          idex_bubble;
  logic          ifid_flush;
  logic          halted;
`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0]   stall_count;
`endif
  logic [4:0]    outs;

  int n_checks = 0;
  int n_errors = 0;

  assign outs = {pc_write, ifid_write, idex_bubble, ifid_flush, halted};

  hazard_stall_controller #(
    .REG_ADDR_W        (RW),
    .LOAD_STALL_CYCLES (2),
    .DRAIN_CYCLES      (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_opcode    (id_opcode),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .branch_taken (branch_taken),
    .exception    (exception),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .halted       (halted)
`ifdef HAZARD_STALL_COUNT_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] observed,
                       input logic [4:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

`ifdef HAZARD_STALL_COUNT_EN
  task automatic check_cnt(input string tag, input logic [15:0] observed,
                           input logic [15:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask
`endif

  task automatic clr();
    id_opcode    = 4'd0;
    id_rs1       = '0;
    id_rs2       = '0;
    ex_mem_read  = 1'b0;
    ex_rd        = '0;
    branch_taken = 1'b0;
    exception    = 1'b0;
  endtask

  task automatic load_use(input logic [RW-1:0] rd);
    ex_mem_read = 1'b1;
    ex_rd       = rd;
    id_rs1      = rd;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    @(negedge clk); #1 check("reset_outputs", outs, O_RST);
    @(negedge clk); #1 check("reset_outputs_held", outs, O_RST);
    rst_n = 1'b1;
    #1 check("run_idle", outs, O_RUN);

    // Load into r0 never hazards.
    ex_mem_read = 1'b1; ex_rd = '0; id_rs1 = '0;
    #1 check("rd_zero_no_stall", outs, O_RUN);
    @(negedge clk); #1 check("rd_zero_still_run", outs, O_RUN);

    // Load-use on rs2: two frozen cycles, then RUN.
    clr(); ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs2 = 4'd3; id_rs1 = 4'd7;
    #1 check("load_use_rs2_c1", outs, O_STALL);
    @(negedge clk); clr();
    #1 check("load_use_stall_c2", outs, O_STALL);
    @(negedge clk);
    #1 check("load_use_release", outs, O_RUN);
`ifdef HAZARD_STALL_COUNT_EN
    check_cnt("stall_count_after_load_use", stall_count, 16'd2);
`endif

    // Register match without a load is not a hazard.
    ex_rd = 4'd5; id_rs1 = 4'd5;
    #1 check("match_without_load", outs, O_RUN);
    ex_mem_read = 1'b1;
    #1 check("load_use_rs1_c1", outs, O_STALL);
    @(negedge clk); clr();
    #1 check("load_use_rs1_c2", outs, O_STALL);
    @(negedge clk);
    #1 check("load_use_rs1_release", outs, O_RUN);

    // Branch with load-use: stall wins, branch flushes once RUN resumes.
    load_use(4'd9); branch_taken = 1'b1;
    #1 check("branch_with_load_use", outs, O_STALL);
    @(negedge clk); clr(); branch_taken = 1'b1;
    #1 check("branch_during_stall", outs, O_STALL);
    @(negedge clk);
    #1 check("branch_after_stall", outs, O_FLUSH);
    @(negedge clk);
    #1 check("branch_state_unchanged", outs, O_FLUSH);

    // HALT with load-use: stall first, then HALT is seen and drains.
    clr(); load_use(4'd2); id_opcode = 4'b1111;
    #1 check("halt_with_load_use", outs, O_STALL);
    @(negedge clk); ex_mem_read = 1'b0;
    #1 check("halt_wait_stall", outs, O_STALL);
    @(negedge clk);
    #1 check("halt_seen_c0", outs, O_STALL);
    @(negedge clk); clr();
    #1 check("drain_c1", outs, O_STALL);
    @(negedge clk); #1 check("drain_c2", outs, O_STALL);
    @(negedge clk); #1 check("drain_c3", outs, O_STALL);
    @(negedge clk); #1 check("halted_c4", outs, O_HALT);
`ifdef HAZARD_STALL_COUNT_EN
    check_cnt("stall_count_before_halt", stall_count, 16'd9);
`endif
    // HALTED ignores every input.
    load_use(4'd4); exception = 1'b1; branch_taken = 1'b1; id_opcode = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1 check("halted_sticky", outs, O_HALT);
    end
    rst_n = 1'b0;
    #1 check("reset_from_halted", outs, O_RST);
    @(negedge clk); rst_n = 1'b1; clr();
    #1 check("run_after_halt_reset", outs, O_RUN);
`ifdef HAZARD_STALL_COUNT_EN
    check_cnt("stall_count_cleared", stall_count, 16'd0);
`endif

    // Reset in the middle of a stall abandons it.
    load_use(4'd6);
    #1 check("stall_before_reset", outs, O_STALL);
    @(negedge clk); clr(); rst_n = 1'b0;
    #1 check("reset_mid_stall", outs, O_RST);
    @(negedge clk); rst_n = 1'b1;
    #1 check("run_after_stall_reset", outs, O_RUN);
`ifdef HAZARD_STALL_COUNT_EN
    check_cnt("stall_count_after_stall_reset", stall_count, 16'd0);
`endif
    @(negedge clk);
    #1 check("run_stays_after_reset", outs, O_RUN);

    // Exception during DRAIN.
    id_opcode = 4'b1111;
    #1 check("halt_seen_exc_test", outs, O_STALL);
    @(negedge clk); clr();
    #1 check("drain_before_exc", outs, O_STALL);
    @(negedge clk); exception = 1'b1;
    #1 check("exception_in_drain", outs, O_EXC);
    @(negedge clk); clr();
    #1 check("halted_after_drain_exc", outs, O_HALT);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Exception beats load-use and branch in RUN.
    load_use(4'd8); branch_taken = 1'b1; exception = 1'b1;
    #1 check("exception_priority_run", outs, O_EXC);
    @(negedge clk); clr();
    #1 check("halted_after_run_exc", outs, O_HALT);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Exception during STALL.
    load_use(4'd1);
    #1 check("stall_before_exc", outs, O_STALL);
    @(negedge clk); clr(); exception = 1'b1;
    #1 check("exception_in_stall", outs, O_EXC);
    @(negedge clk); clr();
    #1 check("halted_after_stall_exc", outs, O_HALT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
